mips_if_stage: RTL and testbench

MIPS_IF_STAGE -- requirements
Module: mips_if_stage

---
 rtl/mips_pkg.sv | 12 +
 rtl/mips_pc_reg.sv | 46 ++++
 rtl/mips_if_stage.sv | 73 +++++++
 tb/tb_mips_if_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS fetch path: datapath width, PC increment and
// the encoding used for pipeline bubbles.
package mips_pkg;
    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] PC_INC    = 32'd4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;   // sll $0,$0,0

    // Instruction fetches are word aligned, so the low two address bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction
endpackage

// File: rtl/mips_pc_reg.sv
// Program counter with its next-PC selection:
// branch > jump > stall (hold) > sequential.
module mips_pc_reg #(
    parameter logic [mips_pkg::XLEN-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      branch_taken,
    input  logic [mips_pkg::XLEN-1:0] branch_target,
    input  logic                      jump_taken,
    input  logic [mips_pkg::XLEN-1:0] jump_target,
    output logic [mips_pkg::XLEN-1:0] pc,
    output logic [mips_pkg::XLEN-1:0] pc_plus4,
    output logic                      redirect
);
    import mips_pkg::*;

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_next;

    assign pc_plus4 = pc_reg + PC_INC;
    assign redirect = branch_taken | jump_taken;

    // The branch belongs to the older instruction, so it beats a jump in decode.
    always_comb begin
        pc_next = pc_plus4;
        if (branch_taken) begin
            pc_next = word_align(branch_target);
        end else if (jump_taken) begin
            pc_next = word_align(jump_target);
        end else if (stall) begin
            pc_next = pc_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc = pc_reg;
endmodule

// File: rtl/mips_if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a counter
// of real instructions handed to decode.
module mips_if_stage #(
    parameter logic [mips_pkg::XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [mips_pkg::XLEN-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      branch_taken,
    input  logic [mips_pkg::XLEN-1:0] branch_target,
    input  logic                      jump_taken,
    input  logic [mips_pkg::XLEN-1:0] jump_target,
    output logic [mips_pkg::XLEN-1:0] imem_addr,
    input  logic [mips_pkg::XLEN-1:0] imem_rdata,
    output logic [mips_pkg::XLEN-1:0] pc,
    output logic [mips_pkg::XLEN-1:0] ifid_instr,
    output logic [mips_pkg::XLEN-1:0] ifid_pc4,
    output logic                      ifid_valid,
    output logic [mips_pkg::XLEN-1:0] fetch_count
);
    import mips_pkg::*;

    logic [XLEN-1:0] pc_plus4;
    logic            redirect;
    logic [XLEN-1:0] ifid_instr_reg;
    logic [XLEN-1:0] ifid_pc4_reg;
    logic            ifid_valid_reg;
    logic [XLEN-1:0] fetch_count_reg;

    mips_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_taken    (jump_taken),
        .jump_target   (jump_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .redirect      (redirect)
    );

    assign imem_addr = pc;

    // A redirect squashes the wrong-path word being fetched this cycle,
    // even when decode is also stalling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_instr_reg  <= NOP_INSTR;
            ifid_pc4_reg    <= '0;
            ifid_valid_reg  <= 1'b0;
            fetch_count_reg <= '0;
        end else if (flush || redirect) begin
            ifid_instr_reg  <= NOP_INSTR;
            ifid_pc4_reg    <= '0;
            ifid_valid_reg  <= 1'b0;
        end else if (!stall) begin
            ifid_instr_reg  <= imem_rdata;
            ifid_pc4_reg    <= pc_plus4;
            ifid_valid_reg  <= 1'b1;
            fetch_count_reg <= fetch_count_reg + 1'b1;
        end
    end

    assign ifid_instr  = ifid_instr_reg;
    assign ifid_pc4    = ifid_pc4_reg;
    assign ifid_valid  = ifid_valid_reg;
    assign fetch_count = fetch_count_reg;
endmodule

// File: tb/tb_mips_if_stage.sv
// Bench for mips_if_stage: two instances (RESET_PC 0 and 32'hFFFF_FFFC) fed by an
// imem that returns word=addr, checked every cycle against a behavioural model.
module tb_mips_if_stage;
    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_taken;
    logic [31:0] jump_target;

    logic [31:0] d_addr  [2];
    logic [31:0] d_rdata [2];
    logic [31:0] d_pc    [2];
    logic [31:0] d_instr [2];
    logic [31:0] d_pc4   [2];
    logic        d_valid [2];
    logic [31:0] d_cnt   [2];

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign d_rdata[0] = d_addr[0];
    assign d_rdata[1] = d_addr[1];

    mips_if_stage #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_taken(jump_taken), .jump_target(jump_target),
        .imem_addr(d_addr[0]), .imem_rdata(d_rdata[0]), .pc(d_pc[0]),
        .ifid_instr(d_instr[0]), .ifid_pc4(d_pc4[0]), .ifid_valid(d_valid[0]),
        .fetch_count(d_cnt[0])
    );

    mips_if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_taken(jump_taken), .jump_target(jump_target),
        .imem_addr(d_addr[1]), .imem_rdata(d_rdata[1]), .pc(d_pc[1]),
        .ifid_instr(d_instr[1]), .ifid_pc4(d_pc4[1]), .ifid_valid(d_valid[1]),
        .fetch_count(d_cnt[1])
    );

    function automatic logic [31:0] reset_pc_of(input int i);
        return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
    endfunction

    // Behavioural model: memory word equals its address, so the fetched word is the PC.
    logic [31:0] m_pc    [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_pc4   [2];
    logic        m_valid [2];
    logic [31:0] m_cnt   [2];

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_pc[i]    <= reset_pc_of(i);
                m_instr[i] <= 32'h0;
                m_pc4[i]   <= 32'h0;
                m_valid[i] <= 1'b0;
                m_cnt[i]   <= 32'h0;
            end else begin
                if (flush || branch_taken || jump_taken) begin
                    m_instr[i] <= 32'h0;
                    m_pc4[i]   <= 32'h0;
                    m_valid[i] <= 1'b0;
                end else if (!stall) begin
                    m_instr[i] <= m_pc[i];
                    m_pc4[i]   <= m_pc[i] + 32'd4;
                    m_valid[i] <= 1'b1;
                    m_cnt[i]   <= m_cnt[i] + 32'd1;
                end
                if (branch_taken)    m_pc[i] <= {branch_target[31:2], 2'b00};
                else if (jump_taken) m_pc[i] <= {jump_target[31:2], 2'b00};
                else if (!stall)     m_pc[i] <= m_pc[i] + 32'd4;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model pc[%0d]", i),          d_pc[i],           m_pc[i]);
                chk($sformatf("model imem_addr[%0d]", i),   d_addr[i],         m_pc[i]);
                chk($sformatf("model ifid_instr[%0d]", i),  d_instr[i],        m_instr[i]);
                chk($sformatf("model ifid_pc4[%0d]", i),    d_pc4[i],          m_pc4[i]);
                chk($sformatf("model ifid_valid[%0d]", i),  32'(d_valid[i]),   32'(m_valid[i]));
                chk($sformatf("model fetch_count[%0d]", i), d_cnt[i],          m_cnt[i]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #3 reset = 1'b0;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; branch_taken = 0; jump_taken = 0;
        branch_target = 32'h0; jump_target = 32'h0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " pc0"},    d_pc[0],           32'h0000_0000);
        chk({tag, " pc1"},    d_pc[1],           32'hFFFF_FFFC);
        chk({tag, " instr0"}, d_instr[0],        32'h0);
        chk({tag, " pc4_0"},  d_pc4[0],          32'h0);
        chk({tag, " valid0"}, 32'(d_valid[0]),   32'h0);
        chk({tag, " cnt0"},   d_cnt[0],          32'h0);
        chk({tag, " cnt1"},   d_cnt[1],          32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1 checking = 1;
        chk_reset_values("initial reset");
        @(posedge clk);
        #3 reset = 1'b0;

        // Free running from reset; the second instance wraps from 32'hFFFF_FFFC.
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("free ifid_pc4 #%0d", k), d_pc4[0], 32'(4 * k));
            $display("free cycle %0d: pc=%08h ifid_pc4=%08h", k, d_pc[0], d_pc4[0]);
            if (k == 1) begin
                chk("wrap pc1 #1",   d_pc[1],  32'h0);
                chk("wrap pc4_1 #1", d_pc4[1], 32'h0);
            end
            if (k == 2) begin
                chk("wrap pc1 #2",   d_pc[1],  32'h4);
                chk("wrap pc4_1 #2", d_pc4[1], 32'h4);
            end
        end
        chk("free fetch_count", d_cnt[0], 32'd4);

        // Stall for two cycles at pc=8.
        do_reset();
        step(); step();
        chk("pre-stall pc", d_pc[0], 32'h8);
        stall = 1;
        for (int k = 1; k <= 2; k++) begin
            step();
            chk($sformatf("stall pc #%0d", k),    d_pc[0],    32'h8);
            chk($sformatf("stall instr #%0d", k), d_instr[0], 32'h4);
            chk($sformatf("stall cnt #%0d", k),   d_cnt[0],   32'd2);
            $display("stall cycle %0d: pc=%08h ifid_instr=%08h", k, d_pc[0], d_instr[0]);
        end
        stall = 0;
        step();
        chk("resume instr", d_instr[0], 32'h8);
        chk("resume pc",    d_pc[0],    32'hC);

        // Branch and jump together: branch wins, target aligned.
        branch_taken = 1; branch_target = 32'h0000_0043;
        jump_taken = 1;   jump_target = 32'h0000_0100;
        step();
        clear_inputs();
        chk("branch pc",    d_pc[0],         32'h40);
        chk("branch valid", 32'(d_valid[0]), 32'h0);
        chk("branch cnt",   d_cnt[0],        32'd3);
        $display("branch+jump: pc=%08h ifid_valid=%0d", d_pc[0], d_valid[0]);
        step();
        chk("after branch pc4", d_pc4[0], 32'h44);

        // Jump overrides stall.
        jump_taken = 1; jump_target = 32'h0000_0102; stall = 1;
        step();
        clear_inputs();
        chk("jump over stall pc", d_pc[0], 32'h100);
        $display("jump over stall: pc=%08h", d_pc[0]);

        // Flush and stall together at pc=20.
        do_reset();
        for (int k = 0; k < 5; k++) step();
        chk("pre-flush pc", d_pc[0], 32'd20);
        flush = 1; stall = 1;
        step();
        chk("flush+stall valid", 32'(d_valid[0]), 32'h0);
        chk("flush+stall instr", d_instr[0],      32'h0);
        chk("flush+stall pc",    d_pc[0],         32'd20);
        $display("flush+stall: pc=%08h ifid_valid=%0d", d_pc[0], d_valid[0]);
        stall = 0;
        step();
        chk("flush pc", d_pc[0], 32'd24);
        clear_inputs();
        step();
        chk("post-flush instr", d_instr[0], 32'd24);

        // Asynchronous reset between edges while stalled with a pending branch.
        stall = 1;
        step();
        branch_taken = 1; branch_target = 32'h80;
        #2 reset = 1'b1;
        #1 chk_reset_values("async reset");
        $display("async reset: pc=%08h fetch_count=%0d", d_pc[0], d_cnt[0]);
        step();
        chk("held reset pc", d_pc[0], 32'h0);
        clear_inputs();
        @(negedge clk);
        #1 reset = 1'b0;
        step();
        chk("post-reset pc4",   d_pc4[0], 32'h4);
        chk("post-reset instr", d_instr[0], 32'h0);
        chk("post-reset cnt",   d_cnt[0], 32'd1);

        step(); step();
        checking = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
